// File: rtl/gate_op_arbiter.sv
// Round-robin share of one bitwise logic unit (AND/OR/XOR/NAND/NOR) among NREQ requesters.
// Latency: gnt in cycle T -> rsp_valid from T+2; response is held until rsp_valid && rsp_ready.
module gate_op_arbiter #(
    parameter int  W    = 4,
    parameter int  NREQ = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NREQ-1:0]     req,
    input  logic [3*NREQ-1:0]   req_op,
    input  logic [W*NREQ-1:0]   req_a,
    input  logic [W*NREQ-1:0]   req_b,
    output logic [NREQ-1:0]     gnt,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [W-1:0]        rsp_data,
    output logic [IDW-1:0]      rsp_id,
    output logic                rsp_err,
    output logic                busy
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t         state, state_nxt;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] sel_idx;
    logic           sel_vld;
    logic [2:0]     lat_op;
    logic [W-1:0]   lat_a, lat_b;
    logic [IDW-1:0] lat_id;
    logic [W-1:0]   res_data;
    logic           res_err;
    logic           rsp_hs;

    assign rsp_hs = rsp_valid && rsp_ready;

    // Scan downward so the requester closest to ptr is the last (winning) assignment.
    always_comb begin
        sel_vld = 1'b0;
        sel_idx = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req[(int'(ptr) + k) % NREQ]) begin
                sel_vld = 1'b1;
                sel_idx = IDW'((int'(ptr) + k) % NREQ);
            end
        end
    end

    always_comb begin
        res_data = '0;
        res_err  = 1'b0;
        case (lat_op)
            3'd0:    res_data = lat_a & lat_b;
            3'd1:    res_data = lat_a | lat_b;
            3'd2:    res_data = lat_a ^ lat_b;
            3'd3:    res_data = ~(lat_a & lat_b);
            3'd4:    res_data = ~(lat_a | lat_b);
            default: res_err  = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (sel_vld) state_nxt = EXEC;
            EXEC:    state_nxt = RESP;
            RESP:    if (rsp_hs) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        gnt  = '0;
        busy = (state != IDLE);
        if (rst_n && state == IDLE && sel_vld) gnt[sel_idx] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr       <= '0;
            lat_op    <= '0;
            lat_a     <= '0;
            lat_b     <= '0;
            lat_id    <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_id    <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (sel_vld) begin
                    lat_op <= req_op[3*sel_idx +: 3];
                    lat_a  <= req_a[W*sel_idx +: W];
                    lat_b  <= req_b[W*sel_idx +: W];
                    lat_id <= sel_idx;
                end
                EXEC: begin
                    rsp_data  <= res_data;
                    rsp_err   <= res_err;
                    rsp_id    <= lat_id;
                    rsp_valid <= 1'b1;
                end
                RESP: if (rsp_hs) begin
                    rsp_valid <= 1'b0;
                    ptr       <= (rsp_id == IDW'(NREQ - 1)) ? '0 : rsp_id + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_gate_op_arbiter.sv
// Directed bench for gate_op_arbiter: expected responses queued at issue, checked by a monitor.
module tb_gate_op_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [11:0] req_op;
    logic [15:0] req_a, req_b;
    logic [3:0]  gnt;
    logic        rsp_valid, rsp_ready;
    logic [3:0]  rsp_data;
    logic [1:0]  rsp_id;
    logic        rsp_err, busy;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    logic [6:0] q[$];

    gate_op_arbiter #(.W(4), .NREQ(4)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_op(req_op), .req_a(req_a),
        .req_b(req_b), .gnt(gnt), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_id(rsp_id), .rsp_err(rsp_err), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic samp();
        @(negedge clk);
    endtask

    // Pops one expectation for every accepted response.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
            if (q.size() == 0) begin
                chk("rsp_unexpected", 32'd1, 32'd0);
            end else begin
                logic [6:0] e;
                e = q.pop_front();
                chk("rsp_data", 32'(rsp_data), 32'(e[6:3]));
                chk("rsp_id",   32'(rsp_id),   32'(e[2:1]));
                chk("rsp_err",  32'(rsp_err),  32'(e[0]));
            end
        end
    end

    task automatic wait_gnt(input logic [3:0] exp, output int gcyc);
        int n;
        n = 0;
        samp();
        while (gnt == 4'b0 && n < 20) begin
            tick();
            samp();
            n++;
        end
        chk("gnt", 32'(gnt), 32'(exp));
        gcyc = cyc;
    endtask

    task automatic do_txn(input int id, input logic [2:0] op, input logic [3:0] a,
                          input logic [3:0] b, input logic [3:0] expd, input logic expe,
                          input logic rdy);
        int g, n;
        tick();
        rsp_ready           = rdy;
        req_op[3*id +: 3]   = op;
        req_a[4*id +: 4]    = a;
        req_b[4*id +: 4]    = b;
        req[id]             = 1'b1;
        if (rdy) q.push_back({expd, 2'(id), expe});
        wait_gnt(4'(1 << id), g);
        tick();
        req[id] = 1'b0;
        samp();
        n = 0;
        while (!rsp_valid && n < 20) begin
            tick();
            samp();
            n++;
        end
        chk("latency", 32'(cyc - g), 32'd2);
        if (rdy) begin
            n = 0;
            while (busy && n < 20) begin
                tick();
                samp();
                n++;
            end
            chk("idle_after_rsp", 32'(busy), 32'd0);
        end
    endtask

    initial begin
        logic [3:0] exp3 [4];
        logic [3:0] exp4 [5];
        int g, prev;
        exp3 = '{4'b1110, 4'b0110, 4'b0111, 4'b0001};
        exp4 = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        rst_n = 1'b0; req = '0; req_op = '0; req_a = '0; req_b = '0; rsp_ready = 1'b1;

        // Reset state, then idle with no requests
        repeat (2) begin
            samp();
            chk("rst_gnt", 32'(gnt), 32'd0);
            chk("rst_valid", 32'(rsp_valid), 32'd0);
            chk("rst_data", 32'(rsp_data), 32'd0);
            chk("rst_id", 32'(rsp_id), 32'd0);
            chk("rst_err", 32'(rsp_err), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
        end
        tick();
        rst_n = 1'b1;
        repeat (2) samp();
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_gnt", 32'(gnt), 32'd0);

        // AND from requester 0
        do_txn(0, 3'd0, 4'b1100, 4'b1010, 4'b1000, 1'b0, 1'b1);

        // OR, XOR, NAND, NOR from requester 2
        for (int i = 0; i < 4; i++)
            do_txn(2, 3'(i + 1), 4'b1100, 4'b1010, exp3[i], 1'b0, 1'b1);

        // Backpressure: response held stable, req ignored while in RESP
        do_txn(1, 3'd2, 4'b1001, 4'b0011, 4'b1010, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            tick();
            req = 4'b1111;
            samp();
            chk("hold_valid", 32'(rsp_valid), 32'd1);
            chk("hold_data", 32'(rsp_data), 32'b1010);
            chk("hold_id", 32'(rsp_id), 32'd1);
            chk("hold_gnt", 32'(gnt), 32'd0);
        end
        q.push_back({4'b1010, 2'd1, 1'b0});
        tick();
        req = 4'b0;
        rsp_ready = 1'b1;
        samp();
        tick();
        samp();
        chk("release_busy", 32'(busy), 32'd0);
        chk("release_valid", 32'(rsp_valid), 32'd0);

        // Illegal op; leaves ptr at 2 so the reset below is observable
        do_txn(1, 3'd5, 4'b1111, 4'b1111, 4'b0000, 1'b1, 1'b1);
        do_txn(1, 3'd6, 4'b1111, 4'b0101, 4'b0000, 1'b1, 1'b0);
        chk("ill_err", 32'(rsp_err), 32'd1);
        chk("ill_data", 32'(rsp_data), 32'd0);
        tick();
        rst_n = 1'b0;
        rsp_ready = 1'b1;
        samp();
        tick();
        rst_n = 1'b1;
        samp();
        chk("rst_resp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_resp_busy", 32'(busy), 32'd0);
        chk("rst_resp_err", 32'(rsp_err), 32'd0);

        // All requesting: grant order 0,1,2,3,0 starting from reset pointer
        tick();
        req_op = {3'd4, 3'd2, 3'd1, 3'd0};
        req_a  = {4'b1010, 4'b1100, 4'b0011, 4'b1111};
        req_b  = {4'b0110, 4'b0110, 4'b0101, 4'b0101};
        req    = 4'b1111;
        q.push_back({4'b0101, 2'd0, 1'b0});
        q.push_back({4'b0111, 2'd1, 1'b0});
        q.push_back({4'b1010, 2'd2, 1'b0});
        q.push_back({4'b0001, 2'd3, 1'b0});
        q.push_back({4'b0101, 2'd0, 1'b0});
        prev = 0;
        for (int i = 0; i < 5; i++) begin
            wait_gnt(exp4[i], g);
            if (i > 0) chk("gnt_gap", 32'(g - prev), 32'd3);
            prev = g;
        end
        tick();
        req = 4'b0;
        repeat (4) samp();
        chk("final_busy", 32'(busy), 32'd0);
        chk("queue_empty", 32'(q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
